otter_cu_fsm: RTL and testbench

//  Multi-cycle control FSM for the OTTER RV32I core. Sits beside the CU decoder.

---
 rtl/otter_cu_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_otter_cu_fsm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/otter_cu_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : otter_cu_fsm
//  Purpose  : Multi-cycle control FSM for the OTTER RV32I core. Sequences
//             fetch, execute, load write-back and interrupt entry, and issues
//             the register-file / memory / CSR / PC write strobes. Fetch and
//             load write-back are stretched to MEM_LAT cycles.
//  Options  : CU_INTR_EN - when defined, the INTR state and interrupt sampling
//             are built; when undefined, intr/csr_mie are ignored and
//             int_taken is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module otter_cu_fsm #(
    parameter int MEM_LAT = 1,   // memory read latency, 1..15
    parameter int CNT_W   = 4    // wait counter width, holds MEM_LAT-1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       intr,
    input  logic       csr_mie,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_we2,
    output logic       mem_rden1,
    output logic       mem_rden2,
    output logic       csr_we,
    output logic       int_taken
);

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP_RG3 = 7'b0110011;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;

    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_MRET  = 3'b000;

    // Terminal count of the wait counter
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    // One-hot encoding: any encoding other than these four is illegal and
    // falls back to FETCH through the default branch.
    typedef enum logic [3:0] {
        ST_FETCH = 4'b0001,
        ST_EXEC  = 4'b0010,
        ST_WB    = 4'b0100,
        ST_INTR  = 4'b1000
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_last;
    logic             int_pend;

    // Raw (un-gated) strobes from the next-state logic
    logic pc_write_raw;
    logic reg_write_raw;
    logic mem_we2_raw;
    logic mem_rden1_raw;
    logic mem_rden2_raw;
    logic csr_we_raw;
    logic int_taken_raw;

    // >= rather than == so an out-of-range count still terminates the wait
    assign cnt_last = (cnt >= CNT_LAST);

`ifdef CU_INTR_EN
    assign int_pend = intr & csr_mie;
`else
    logic unused_intr_inputs;
    assign unused_intr_inputs = intr ^ csr_mie;
    assign int_pend           = 1'b0;
`endif

    // State and wait-counter register with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter and strobe decode
    always_comb begin
        state_nxt     = ST_FETCH;
        cnt_nxt       = '0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_we2_raw   = 1'b0;
        mem_rden1_raw = 1'b0;
        mem_rden2_raw = 1'b0;
        csr_we_raw    = 1'b0;
        int_taken_raw = 1'b0;

        case (state)
            ST_FETCH: begin
                mem_rden1_raw = 1'b1;
                if (cnt_last) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_EXEC;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = ST_FETCH;
                end
            end

            ST_EXEC: begin
                // Non-load instructions finish here, so this is where a
                // pending interrupt is sampled for them.
                cnt_nxt   = '0;
                state_nxt = int_pend ? ST_INTR : ST_FETCH;
                case (opcode)
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                    OPC_OP_IMM, OPC_OP_RG3: begin
                        reg_write_raw = 1'b1;
                        pc_write_raw  = 1'b1;
                    end
                    OPC_BRANCH: begin
                        pc_write_raw = 1'b1;
                    end
                    OPC_STORE: begin
                        mem_we2_raw  = 1'b1;
                        pc_write_raw = 1'b1;
                    end
                    OPC_LOAD: begin
                        // PC advances at the end of write-back instead
                        mem_rden2_raw = 1'b1;
                        state_nxt     = ST_WB;
                    end
                    OPC_SYS: begin
                        pc_write_raw = 1'b1;
                        if (func3 == F3_CSRRW) begin
                            csr_we_raw    = 1'b1;
                            reg_write_raw = 1'b1;
                        end else if (func3 == F3_MRET) begin
                            csr_we_raw = 1'b0;
                        end
                    end
                    default: begin
                        // Unknown opcode retires as a NOP
                        pc_write_raw = 1'b1;
                    end
                endcase
            end

            ST_WB: begin
                mem_rden2_raw = 1'b1;
                if (cnt_last) begin
                    reg_write_raw = 1'b1;
                    pc_write_raw  = 1'b1;
                    cnt_nxt       = '0;
                    state_nxt     = int_pend ? ST_INTR : ST_FETCH;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = ST_WB;
                end
            end

`ifdef CU_INTR_EN
            ST_INTR: begin
                int_taken_raw = 1'b1;
                pc_write_raw  = 1'b1;
                cnt_nxt       = '0;
                state_nxt     = ST_FETCH;
            end
`endif

            default: begin
                state_nxt = ST_FETCH;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Reset masks every strobe so nothing half-finished reaches the datapath
    assign pc_write  = pc_write_raw  & ~RST;
    assign reg_write = reg_write_raw & ~RST;
    assign mem_we2   = mem_we2_raw   & ~RST;
    assign mem_rden1 = mem_rden1_raw & ~RST;
    assign mem_rden2 = mem_rden2_raw & ~RST;
    assign csr_we    = csr_we_raw    & ~RST;
`ifdef CU_INTR_EN
    assign int_taken = int_taken_raw & ~RST;
`else
    logic unused_int_taken_raw;
    assign unused_int_taken_raw = int_taken_raw;
    assign int_taken            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_otter_cu_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_otter_cu_fsm
//  Purpose  : Scoreboard bench for otter_cu_fsm, with one instance at
//             MEM_LAT=2 and one at MEM_LAT=3. Per-cycle expected strobe
//             vectors {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2,
//             csr_we, int_taken} are queued per instruction and popped each
//             cycle. Works in both CU_INTR_EN builds.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_otter_cu_fsm;

`ifdef CU_INTR_EN
    localparam bit INTR_EN = 1'b1;
`else
    localparam bit INTR_EN = 1'b0;
`endif

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP_RG3 = 7'b0110011;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;

    // Expected vectors, bit order {pc, rw, we2, rd1, rd2, csr, it}
    localparam logic [6:0] V_NONE  = 7'b0000000;
    localparam logic [6:0] V_FETCH = 7'b0001000;
    localparam logic [6:0] V_RW    = 7'b1100000;
    localparam logic [6:0] V_PC    = 7'b1000000;
    localparam logic [6:0] V_ST    = 7'b1010000;
    localparam logic [6:0] V_LDX   = 7'b0000100;
    localparam logic [6:0] V_LDWB  = 7'b1100100;
    localparam logic [6:0] V_CSR   = 7'b1100010;
    localparam logic [6:0] V_INTR  = 7'b1000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst2 = 1'b1, intr2 = 1'b0, mie2 = 1'b0;
    logic [6:0] op2 = 7'd0;
    logic [2:0] f32 = 3'd0;
    logic       pc2, rw2, we2_2, rd1_2, rd2_2, csr2, it2;

    logic       rst3 = 1'b1, intr3 = 1'b0, mie3 = 1'b0;
    logic [6:0] op3 = 7'd0;
    logic [2:0] f33 = 3'd0;
    logic       pc3, rw3, we2_3, rd1_3, rd2_3, csr3, it3;

    otter_cu_fsm #(.MEM_LAT(2), .CNT_W(4)) u_dut2 (
        .CLK(clk), .RST(rst2), .intr(intr2), .csr_mie(mie2),
        .opcode(op2), .func3(f32),
        .pc_write(pc2), .reg_write(rw2), .mem_we2(we2_2), .mem_rden1(rd1_2),
        .mem_rden2(rd2_2), .csr_we(csr2), .int_taken(it2)
    );

    otter_cu_fsm #(.MEM_LAT(3), .CNT_W(4)) u_dut3 (
        .CLK(clk), .RST(rst3), .intr(intr3), .csr_mie(mie3),
        .opcode(op3), .func3(f33),
        .pc_write(pc3), .reg_write(rw3), .mem_we2(we2_3), .mem_rden1(rd1_3),
        .mem_rden2(rd2_3), .csr_we(csr3), .int_taken(it3)
    );

    logic [6:0] exp_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;

    logic [6:0] ops_tbl [10] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                                 OPC_OP_IMM, OPC_OP_RG3, OPC_BRANCH,
                                 OPC_STORE, OPC_LOAD, OPC_SYS};

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    endtask

    function automatic logic [6:0] obs_vec(input int sel);
        if (sel == 3) return {pc3, rw3, we2_3, rd1_3, rd2_3, csr3, it3};
        return {pc2, rw2, we2_2, rd1_2, rd2_2, csr2, it2};
    endfunction

    // Expected EXEC-cycle vector from the instruction class
    function automatic logic [6:0] exec_vec(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP_RG3: return V_RW;
            OPC_BRANCH: return V_PC;
            OPC_STORE:  return V_ST;
            OPC_LOAD:   return V_LDX;
            OPC_SYS:    return (f3 == 3'b001) ? V_CSR : V_PC;
            default:    return V_PC;
        endcase
    endfunction

    task automatic push_instr(input int lat, input logic [6:0] op, input logic [2:0] f3,
                              input logic ir, input logic mie);
        for (int k = 0; k < lat; k++) exp_q.push_back(V_FETCH);
        exp_q.push_back(exec_vec(op, f3));
        if (op == OPC_LOAD) begin
            for (int k = 0; k < lat - 1; k++) exp_q.push_back(V_LDX);
            exp_q.push_back(V_LDWB);
        end
        if (INTR_EN && ir && mie) exp_q.push_back(V_INTR);
    endtask

    // Run one instruction on the selected instance; rst_at >= 0 asserts
    // reset at that cycle index and abandons the instruction.
    task automatic run(input int sel, input logic [6:0] op, input logic [2:0] f3,
                       input logic ir, input logic mie, input int rst_at, input string tag);
        int         n;
        logic [6:0] exp;
        push_instr((sel == 3) ? 3 : 2, op, f3, ir, mie);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                if (sel == 3) begin
                    rst3 = 1'b0; op3 = op; f33 = f3; intr3 = ir; mie3 = mie;
                end else begin
                    rst2 = 1'b0; op2 = op; f32 = f3; intr2 = ir; mie2 = mie;
                end
            end
            if (i == rst_at) begin
                if (sel == 3) rst3 = 1'b1;
                else          rst2 = 1'b1;
            end
            @(negedge clk);
            exp = exp_q.pop_front();
            if (i == rst_at) exp = V_NONE;
            check($sformatf("%s c%0d", tag, i), obs_vec(sel), exp);
            if (i == rst_at) begin
                exp_q.delete();
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Both instances held in reset: every strobe must be low
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("reset2 c%0d", i), obs_vec(2), V_NONE);
            check($sformatf("reset3 c%0d", i), obs_vec(3), V_NONE);
        end

        // MEM_LAT = 2 instance
        run(2, OPC_OP_RG3, 3'd0, 1'b0, 1'b0, -1, "rg3");
        run(2, OPC_OP_RG3, 3'd0, 1'b0, 1'b0, -1, "rg3b");
        run(2, OPC_LUI,    3'd0, 1'b0, 1'b0, -1, "lui");
        run(2, OPC_BRANCH, 3'd0, 1'b0, 1'b0, -1, "branch");
        run(2, OPC_STORE,  3'd0, 1'b1, 1'b1, -1, "store_int");
        run(2, OPC_STORE,  3'd0, 1'b1, 1'b0, -1, "store_mie0");
        run(2, OPC_LOAD,   3'd0, 1'b0, 1'b0, -1, "load2");
        run(2, OPC_LOAD,   3'd0, 1'b1, 1'b1, -1, "load2_int");
        run(2, OPC_SYS,    3'b001, 1'b0, 1'b0, -1, "csrrw");
        run(2, OPC_SYS,    3'b000, 1'b1, 1'b1, -1, "mret_int");
        run(2, OPC_SYS,    3'b010, 1'b0, 1'b0, -1, "sys_other");
        run(2, 7'b1111111, 3'd0, 1'b0, 1'b0, -1, "nop_op");
        run(2, OPC_JALR,   3'd0, 1'b1, 1'b0, -1, "jalr_mie0");

        // Long stretch with interrupt requested and enabled
        for (int j = 0; j < 24; j++) begin
            logic [6:0] op;
            logic [2:0] f3;
            op = ops_tbl[$urandom_range(0, 9)];
            f3 = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b001;
            run(2, op, f3, 1'b1, 1'b1, -1, $sformatf("soak%0d", j));
        end
        @(posedge clk); #1;
        rst2 = 1'b1;

        // MEM_LAT = 3 instance
        run(3, OPC_LOAD,   3'd0, 1'b0, 1'b0, -1, "load3");
        run(3, OPC_LOAD,   3'd0, 1'b0, 1'b0, 5,  "load3_rst");
        run(3, OPC_OP_RG3, 3'd0, 1'b0, 1'b0, -1, "after_rst");
        run(3, OPC_LOAD,   3'd0, 1'b1, 1'b1, -1, "load3_int");
        run(3, OPC_STORE,  3'd0, 1'b0, 1'b0, -1, "store3");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
